morse_char_assembler: RTL and testbench

//  Sequential successor to the combinational Morse letter decoder. Collects a dit/dah

---
 rtl/morse_char_assembler.sv | 178 +++++++++++++++++
 tb/tb_morse_char_assembler.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_char_assembler.sv
// Morse character assembler: collects dit/dah symbols, closes characters on gaps and
// emits decoded ASCII (A-Z, optional 0-9, space) over a valid/ready handshake.
module morse_char_assembler #(
  parameter int unsigned MAX_LEN    = 6,
  parameter bit          EN_DIGITS  = 1'b1,
  parameter bit          EMIT_SPACE = 1'b1,
  localparam int unsigned LEN_W     = $clog2(MAX_LEN + 1),
  localparam int unsigned CHAR_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sym_valid,
  input  logic              sym_dah,
  input  logic              char_end,
  input  logic              word_end,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CHAR_W-1:0] out_char,
  output logic              out_err,
  output logic [LEN_W-1:0]  len_dbg
);

  localparam logic [CHAR_W-1:0] CHAR_SPACE = 8'h20;

  typedef enum logic [1:0] {S_COLLECT, S_EMIT_CHAR, S_EMIT_SPACE} state_t;

  state_t             state;
  logic [MAX_LEN-1:0] seq, seq_n;
  logic [LEN_W-1:0]   len, len_n;
  logic               ovf, ovf_n;
  logic               space_pend, last_was_space;
  logic [4:0]         sym_bits;
  logic [CHAR_W-1:0]  dec_char;
  logic               dec_err;

  assign len_dbg = len;

  // Buffer contents including a symbol that arrives in the same cycle as a gap.
  always_comb begin
    seq_n = seq;
    len_n = len;
    ovf_n = ovf;
    if (in_ready && sym_valid) begin
      if (len == LEN_W'(MAX_LEN)) begin
        ovf_n = 1'b1;
      end else begin
        seq_n = {seq[MAX_LEN-2:0], sym_dah};
        len_n = len + LEN_W'(1);
      end
    end
  end

  // Decode; the first symbol sits in the MSB of the significant bits.
  always_comb begin
    dec_char = CHAR_SPACE;
    sym_bits = 5'(seq_n);
    if (!ovf_n) begin
      case (32'(len_n))
        1: dec_char = sym_bits[0] ? "T" : "E";
        2: case (sym_bits[1:0])
             2'b00: dec_char = "I";
             2'b01: dec_char = "A";
             2'b10: dec_char = "N";
             default: dec_char = "M";
           endcase
        3: case (sym_bits[2:0])
             3'b000: dec_char = "S";
             3'b001: dec_char = "U";
             3'b010: dec_char = "R";
             3'b011: dec_char = "W";
             3'b100: dec_char = "D";
             3'b101: dec_char = "K";
             3'b110: dec_char = "G";
             default: dec_char = "O";
           endcase
        4: case (sym_bits[3:0])
             4'b0000: dec_char = "H";
             4'b0001: dec_char = "V";
             4'b0010: dec_char = "F";
             4'b0100: dec_char = "L";
             4'b0110: dec_char = "P";
             4'b0111: dec_char = "J";
             4'b1000: dec_char = "B";
             4'b1001: dec_char = "X";
             4'b1010: dec_char = "C";
             4'b1011: dec_char = "Y";
             4'b1100: dec_char = "Z";
             4'b1101: dec_char = "Q";
             default: dec_char = CHAR_SPACE;
           endcase
        5: if (EN_DIGITS) begin
             case (sym_bits)
               5'b11111: dec_char = "0";
               5'b01111: dec_char = "1";
               5'b00111: dec_char = "2";
               5'b00011: dec_char = "3";
               5'b00001: dec_char = "4";
               5'b00000: dec_char = "5";
               5'b10000: dec_char = "6";
               5'b11000: dec_char = "7";
               5'b11100: dec_char = "8";
               5'b11110: dec_char = "9";
               default:  dec_char = CHAR_SPACE;
             endcase
           end
        default: dec_char = CHAR_SPACE;
      endcase
    end
    dec_err = (dec_char == CHAR_SPACE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_COLLECT;
      seq            <= '0;
      len            <= '0;
      ovf            <= 1'b0;
      space_pend     <= 1'b0;
      last_was_space <= 1'b0;
      out_valid      <= 1'b0;
      out_char       <= CHAR_SPACE;
      out_err        <= 1'b0;
      in_ready       <= 1'b1;
    end else begin
      case (state)
        S_COLLECT: begin
          if ((char_end || word_end) && len_n != '0) begin
            out_valid      <= 1'b1;
            out_char       <= dec_char;
            out_err        <= dec_err;
            seq            <= '0;
            len            <= '0;
            ovf            <= 1'b0;
            space_pend     <= word_end & EMIT_SPACE;
            last_was_space <= 1'b0;
            in_ready       <= 1'b0;
            state          <= S_EMIT_CHAR;
          end else if (word_end && EMIT_SPACE && !last_was_space) begin
            out_valid <= 1'b1;
            out_char  <= CHAR_SPACE;
            out_err   <= 1'b0;
            in_ready  <= 1'b0;
            state     <= S_EMIT_SPACE;
          end else begin
            seq <= seq_n;
            len <= len_n;
            ovf <= ovf_n;
          end
        end
        S_EMIT_CHAR: begin
          if (out_ready) begin
            if (space_pend) begin
              out_char   <= CHAR_SPACE;
              out_err    <= 1'b0;
              space_pend <= 1'b0;
              state      <= S_EMIT_SPACE;
            end else begin
              out_valid <= 1'b0;
              in_ready  <= 1'b1;
              state     <= S_COLLECT;
            end
          end
        end
        S_EMIT_SPACE: begin
          if (out_ready) begin
            out_valid      <= 1'b0;
            in_ready       <= 1'b1;
            last_was_space <= 1'b1;
            state          <= S_COLLECT;
          end
        end
        default: state <= S_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_char_assembler.sv
// Bench for morse_char_assembler: directed scenarios plus a randomized run checked
// against a pattern-table model (digits-enabled and digits-disabled instances in parallel).
module tb_morse_char_assembler;

  localparam logic [7:0] SP = 8'h20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sym_valid = 1'b0, sym_dah = 1'b0, char_end = 1'b0, word_end = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready, out_valid, out_err;
  logic [7:0] out_char;
  logic [2:0] len_dbg;
  logic       in_ready0, out_valid0, out_err0;
  logic [7:0] out_char0;
  logic [2:0] len_dbg0;

  int n_tests = 0;
  int n_fail  = 0;
  bit lws     = 1'b0;

  string tbl [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                      ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                      "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                      "-----", ".----", "..---", "...--", "....-", ".....", "-....",
                      "--...", "---..", "----."};

  always #5 clk = ~clk;

  morse_char_assembler #(.MAX_LEN(6), .EN_DIGITS(1'b1), .EMIT_SPACE(1'b1)) u_dut (
    .clk(clk), .rst(rst), .sym_valid(sym_valid), .sym_dah(sym_dah),
    .char_end(char_end), .word_end(word_end), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char),
    .out_err(out_err), .len_dbg(len_dbg));

  morse_char_assembler #(.MAX_LEN(6), .EN_DIGITS(1'b0), .EMIT_SPACE(1'b1)) u_nodig (
    .clk(clk), .rst(rst), .sym_valid(sym_valid), .sym_dah(sym_dah),
    .char_end(char_end), .word_end(word_end), .in_ready(in_ready0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_char(out_char0),
    .out_err(out_err0), .len_dbg(len_dbg0));

  // Reference decode: look the dot/dash string up in the International Morse table.
  function automatic void model(input string pat, input bit dig, output logic [7:0] c,
                                output bit e);
    c = SP;
    e = 1'b1;
    for (int i = 0; i < 36; i++) begin
      if (pat == tbl[i] && (i < 26 || dig)) begin
        c = (i < 26) ? 8'(65 + i) : 8'(48 + i - 26);
        e = 1'b0;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sym(input bit d);
    sym_valid = 1'b1;
    sym_dah   = d;
    tick();
    sym_valid = 1'b0;
    sym_dah   = 1'b0;
  endtask

  task automatic pulse_close(input bit w);
    if (w) word_end = 1'b1;
    else   char_end = 1'b1;
    tick();
    word_end = 1'b0;
    char_end = 1'b0;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_tests++;
    if (out_valid !== 1'b0 || out_char !== SP || out_err !== 1'b0 || len_dbg !== 3'd0 ||
        in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset got v=%b c=%h e=%b len=%0d rdy=%b want v=0 c=20 e=0 len=0 rdy=1",
               out_valid, out_char, out_err, len_dbg, in_ready);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_letter_a();
    send_sym(1'b0);
    n_tests++;
    if (len_dbg !== 3'd1) begin
      n_fail++; $display("FAIL a_len1 got %0d want 1", len_dbg);
    end
    send_sym(1'b1);
    pulse_close(1'b0);
    n_tests++;
    if (out_valid !== 1'b1 || out_char !== 8'h41 || out_err !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL a_out got v=%b c=%h e=%b rdy=%b want v=1 c=41 e=0 rdy=0",
               out_valid, out_char, out_err, in_ready);
    end
    accept();
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || len_dbg !== 3'd0) begin
      n_fail++;
      $display("FAIL a_done got v=%b rdy=%b len=%0d want v=0 rdy=1 len=0",
               out_valid, in_ready, len_dbg);
    end
  endtask

  task automatic test_digits();
    repeat (5) send_sym(1'b1);
    pulse_close(1'b0);
    n_tests++;
    if (out_char !== 8'h30 || out_err !== 1'b0 || out_char0 !== SP || out_err0 !== 1'b1) begin
      n_fail++;
      $display("FAIL digit0 got c=%h e=%b nodig c=%h e=%b want c=30 e=0 nodig c=20 e=1",
               out_char, out_err, out_char0, out_err0);
    end
    accept();
    repeat (4) send_sym(1'b0);
    send_sym(1'b1);
    pulse_close(1'b0);
    n_tests++;
    if (out_char !== 8'h34 || out_err !== 1'b0) begin
      n_fail++; $display("FAIL digit4 got c=%h e=%b want c=34 e=0", out_char, out_err);
    end
    accept();
  endtask

  task automatic test_overlength();
    for (int i = 0; i < 7; i++) begin
      send_sym(1'b0);
      n_tests++;
      if (len_dbg !== 3'((i < 6) ? i + 1 : 6)) begin
        n_fail++; $display("FAIL ovf_len%0d got %0d", i, len_dbg);
      end
    end
    pulse_close(1'b0);
    n_tests++;
    if (out_char !== SP || out_err !== 1'b1) begin
      n_fail++; $display("FAIL ovf_out got c=%h e=%b want c=20 e=1", out_char, out_err);
    end
    accept();
    send_sym(1'b1);
    send_sym(1'b0);
    send_sym(1'b0);
    pulse_close(1'b0);
    n_tests++;
    if (out_char !== 8'h44 || out_err !== 1'b0) begin
      n_fail++; $display("FAIL ovf_next got c=%h e=%b want c=44 e=0", out_char, out_err);
    end
    accept();
  endtask

  task automatic test_backpressure();
    repeat (3) send_sym(1'b0);
    pulse_close(1'b1);
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_char !== 8'h53 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d got v=%b c=%h rdy=%b want v=1 c=53 rdy=0",
                 i, out_valid, out_char, in_ready);
      end
      sym_valid = 1'b1;
      sym_dah   = 1'b1;
      tick();
    end
    sym_valid = 1'b0;
    sym_dah   = 1'b0;
    out_ready = 1'b1;
    n_tests++;
    if (out_valid !== 1'b1 || out_char !== 8'h53) begin
      n_fail++; $display("FAIL bp_s got v=%b c=%h want v=1 c=53", out_valid, out_char);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_char !== SP || out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_space got v=%b c=%h e=%b want v=1 c=20 e=0", out_valid, out_char, out_err);
    end
    tick();
    out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || len_dbg !== 3'd0) begin
      n_fail++;
      $display("FAIL bp_done got v=%b rdy=%b len=%0d want v=0 rdy=1 len=0",
               out_valid, in_ready, len_dbg);
    end
  endtask

  task automatic test_spaces();
    send_sym(1'b0);
    pulse_close(1'b0);
    accept();
    pulse_close(1'b1);
    n_tests++;
    if (out_valid !== 1'b1 || out_char !== SP || out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL sp_first got v=%b c=%h e=%b want v=1 c=20 e=0", out_valid, out_char, out_err);
    end
    accept();
    pulse_close(1'b1);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL sp_second got v=%b want v=0", out_valid);
    end
    pulse_close(1'b0);
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL sp_charend got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_same_cycle();
    sym_valid = 1'b1; sym_dah = 1'b1; char_end = 1'b1;
    tick();
    sym_valid = 1'b0; sym_dah = 1'b0; char_end = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || out_char !== 8'h54 || out_err !== 1'b0 || len_dbg !== 3'd0) begin
      n_fail++;
      $display("FAIL same_t got v=%b c=%h e=%b len=%0d want v=1 c=54 e=0 len=0",
               out_valid, out_char, out_err, len_dbg);
    end
    accept();
    send_sym(1'b0);
    send_sym(1'b0);
    char_end = 1'b1; word_end = 1'b1;
    tick();
    char_end = 1'b0; word_end = 1'b0;
    n_tests++;
    if (out_char !== 8'h49) begin
      n_fail++; $display("FAIL same_i got c=%h want c=49", out_char);
    end
    accept();
    n_tests++;
    if (out_valid !== 1'b1 || out_char !== SP) begin
      n_fail++; $display("FAIL same_isp got v=%b c=%h want v=1 c=20", out_valid, out_char);
    end
    accept();
    lws = 1'b1;
  endtask

  task automatic test_reset_mid_emit();
    send_sym(1'b0);
    send_sym(1'b1);
    pulse_close(1'b0);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_char !== SP || out_err !== 1'b0 || in_ready !== 1'b1 ||
        len_dbg !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_mid got v=%b c=%h e=%b rdy=%b len=%0d want v=0 c=20 e=0 rdy=1 len=0",
               out_valid, out_char, out_err, in_ready, len_dbg);
    end
    tick();
    rst = 1'b0;
    lws = 1'b0;
    tick();
    pulse_close(1'b1);
    n_tests++;
    if (out_valid !== 1'b1 || out_char !== SP) begin
      n_fail++; $display("FAIL rst_space got v=%b c=%h want v=1 c=20", out_valid, out_char);
    end
    accept();
    lws = 1'b1;
  endtask

  task automatic test_random();
    logic [7:0] qc[$], qc0[$];
    bit         qe[$], qe0[$];
    logic [7:0] c, c0;
    bit         e, e0, w, d, merge;
    int         n;
    string      pat;
    for (int t = 0; t < 80; t++) begin
      n = ($urandom_range(0, 9) == 0) ? 0 :
          ($urandom_range(0, 7) == 0) ? int'($urandom_range(6, 8)) : int'($urandom_range(1, 5));
      w     = 1'($urandom_range(0, 1));
      merge = (n > 0) && ($urandom_range(0, 2) == 0);
      pat   = "";
      for (int i = 0; i < n; i++) begin
        d = 1'($urandom_range(0, 1));
        if (d) pat = {pat, "-"};
        else   pat = {pat, "."};
        if (merge && i == n - 1) begin
          sym_valid = 1'b1; sym_dah = d;
          if (w) word_end = 1'b1;
          else   char_end = 1'b1;
          tick();
          sym_valid = 1'b0; sym_dah = 1'b0; word_end = 1'b0; char_end = 1'b0;
        end else begin
          send_sym(d);
        end
      end
      if (n > 0 && !merge) begin
        n_tests++;
        if (len_dbg !== 3'((n < 6) ? n : 6)) begin
          n_fail++; $display("FAIL rnd_len t=%0d got %0d n=%0d", t, len_dbg, n);
        end
      end
      if (n > 0) begin
        model(pat, 1'b1, c, e);
        model(pat, 1'b0, c0, e0);
        qc.push_back(c); qe.push_back(e); qc0.push_back(c0); qe0.push_back(e0);
        lws = 1'b0;
      end
      if (w && (n > 0 || !lws)) begin
        qc.push_back(SP); qe.push_back(1'b0); qc0.push_back(SP); qe0.push_back(1'b0);
      end
      if (!merge) pulse_close(w);
      while (qc.size() > 0) begin
        c = qc.pop_front(); e = qe.pop_front(); c0 = qc0.pop_front(); e0 = qe0.pop_front();
        repeat ($urandom_range(0, 2)) tick();
        out_ready = 1'b1;
        n_tests++;
        if (out_valid !== 1'b1 || out_char !== c || out_err !== e || in_ready !== 1'b0 ||
            out_valid0 !== 1'b1 || out_char0 !== c0 || out_err0 !== e0) begin
          n_fail++;
          $display("FAIL rnd_out t=%0d pat=%s got v=%b c=%h e=%b nodig v=%b c=%h e=%b want c=%h e=%b nodig c=%h e=%b",
                   t, pat, out_valid, out_char, out_err, out_valid0, out_char0, out_err0,
                   c, e, c0, e0);
        end
        tick();
        out_ready = 1'b0;
        if (c == SP && !e) lws = 1'b1;
      end
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || len_dbg !== 3'd0) begin
        n_fail++;
        $display("FAIL rnd_idle t=%0d got v=%b rdy=%b len=%0d want v=0 rdy=1 len=0",
                 t, out_valid, in_ready, len_dbg);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_letter_a();
    test_digits();
    test_overlength();
    test_backpressure();
    test_spaces();
    test_same_cycle();
    test_reset_mid_emit();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
